acq_sequencer: RTL
==================

ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 SHALL have parameter NCH, default 2, number of ADC channels.
REQ-002 SHALL have parameter CNT_W, default 32, width of timing registers and the phase counter.
REQ-003 SHALL have parameter CTRL_W, default 10, width of the per-channel ADC control word.
REQ-004 SHALL have parameter AGC_W, default 12, width of the AGC DAC code.
REQ-005 SHALL have parameter AGC_RST, default 12'h555, agc_data reset value.
REQ-006 SHALL have ports, in order:
- clk  in  1  system clock.
- arstn  in  1  reset: asynchronous, active-low.
- start  in  1  start request, sampled every cycle.
- abort  in  1  stop request, sampled every cycle.
- mode  in  2  0 one-shot, 1 periodic, 2 continuous, 3 treated as one-shot.
- t_agc  in  CNT_W  AGC settle cycles.
- t_ctrl  in  CNT_W  control-load-to-enable cycles.
- t_acq  in  CNT_W  enable window cycles.
- t_gap  in  CNT_W  inter-frame gap cycles (periodic mode).
- agc_code  in  AGC_W  AGC code to load.
- ctrlword_in  in  NCH*CTRL_W  per-channel control words, channel 0 in the LSBs.
- ch_mask  in  NCH  channel enable mask.
- agc_load  out  1  one-cycle AGC SPI load strobe.
- agc_data  out  AGC_W  AGC code.
- adc_ldctrl  out  NCH  one-cycle control-load strobes.
- adc_ctrlword  out  NCH*CTRL_W  latched control words.
- adc_enable  out  NCH  acquisition enables.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle end-of-sequence pulse.
- frame_cnt  out  16  completed acquisition windows.

Function
REQ-007 SHALL implement states IDLE, AGC, CTRL, SETTLE, ACQ and GAP, all registered.
REQ-008 SHALL, in IDLE with start=1 and abort=0, latch mode, all t_* inputs, agc_code, ctrlword_in and ch_mask into shadow registers and enter AGC; input changes while busy SHALL have no effect.
REQ-009 SHALL assert agc_load for exactly the first cycle of AGC, with agc_data = shadowed code from that cycle onward.
REQ-010 SHALL give each timed state (AGC=t_agc, SETTLE=t_ctrl, ACQ=t_acq, GAP=t_gap) a duration of max(t,1) cycles, counted by one CNT_W phase counter cleared on every state entry.
REQ-011 SHALL make CTRL last exactly 1 cycle and drive adc_ldctrl = shadow ch_mask and adc_ctrlword = shadow words in that cycle; adc_ctrlword SHALL hold its value afterwards.
REQ-012 SHALL drive adc_enable = shadow ch_mask in every ACQ cycle and 0 in all other states.
REQ-013 SHALL act as follows on ACQ expiry, incrementing frame_cnt (mod 2^16) in the same cycle:
- one-shot: enter IDLE and pulse done.
- periodic: enter GAP, then return to ACQ; no AGC or control reload.
REQ-014 SHALL, in continuous mode, remain in ACQ indefinitely; the phase counter SHALL NOT expire the state and frame_cnt SHALL NOT increment.
REQ-015 SHALL, on abort=1 in any non-IDLE state, enter IDLE on the next edge; that edge SHALL clear adc_enable, agc_load and adc_ldctrl.
REQ-016 SHALL NOT pulse done on abort; an abort in ACQ SHALL still increment frame_cnt (partial frame).
REQ-017 SHALL, when start=1 and abort=1 in the same IDLE cycle, remain in IDLE (abort wins); start while busy SHALL be ignored.
REQ-018 SHALL clear frame_cnt on each accepted start.
REQ-019 SHALL produce an all-zero ch_mask sequence with correct timing and zero-valued strobes and enables.

Reset
REQ-020 SHALL, while arstn=0, hold state IDLE; all outputs 0 except agc_data=AGC_RST; shadows and counters 0.
REQ-021 SHALL accept start no earlier than the first clk edge after arstn deassertion; reset mid-sequence SHALL drop enables immediately (asynchronously).

Verification
REQ-022 One-shot, NCH=2, t_agc=3, t_ctrl=2, t_acq=5, mask=2'b11, start at cycle 0 -> agc_load at cycle 1, adc_ldctrl=2'b11 at cycle 4, enable at cycles 7-11, done at cycle 12, frame_cnt=1.
REQ-023 Periodic, t_acq=4, t_gap=2 -> enable pattern 4 on / 2 off repeating; frame_cnt +1 per window; abort mid-ACQ -> enable 0 the next cycle, no done.
REQ-024 All t_*=0 -> each timed state lasts exactly 1 cycle; start-to-done takes 5 cycles.
REQ-025 Continuous, t_acq=3 -> enable held >1000 cycles with frame_cnt=0; abort -> IDLE, frame_cnt=1.
REQ-026 start+abort in the same cycle, start while busy, inputs changed while busy, arstn asserted mid-ACQ -> no effect, no effect, shadow values used, outputs at reset values.

Source files
------------

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: loads an AGC code, strobes per-channel ADC control words,
// then opens timed acquisition windows in one-shot, periodic or continuous mode.
module acq_sequencer #(
    parameter int                 NCH     = 2,
    parameter int                 CNT_W   = 32,
    parameter int                 CTRL_W  = 10,
    parameter int                 AGC_W   = 12,
    parameter logic [AGC_W-1:0]   AGC_RST = 12'h555
) (
    input  logic                    clk,
    input  logic                    arstn,
    input  logic                    start,
    input  logic                    abort,
    input  logic [1:0]              mode,
    input  logic [CNT_W-1:0]        t_agc,
    input  logic [CNT_W-1:0]        t_ctrl,
    input  logic [CNT_W-1:0]        t_acq,
    input  logic [CNT_W-1:0]        t_gap,
    input  logic [AGC_W-1:0]        agc_code,
    input  logic [NCH*CTRL_W-1:0]   ctrlword_in,
    input  logic [NCH-1:0]          ch_mask,
    output logic                    agc_load,
    output logic [AGC_W-1:0]        agc_data,
    output logic [NCH-1:0]          adc_ldctrl,
    output logic [NCH*CTRL_W-1:0]   adc_ctrlword,
    output logic [NCH-1:0]          adc_enable,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_AGC    = 3'd1,
        S_CTRL   = 3'd2,
        S_SETTLE = 3'd3,
        S_ACQ    = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              mode_q, mode_d;
    logic [CNT_W-1:0]        t_agc_q, t_agc_d, t_ctrl_q, t_ctrl_d;
    logic [CNT_W-1:0]        t_acq_q, t_acq_d, t_gap_q, t_gap_d;
    logic [NCH*CTRL_W-1:0]   words_q, words_d;
    logic [NCH-1:0]          mask_q, mask_d;
    logic                    agc_load_q, agc_load_d;
    logic [AGC_W-1:0]        agc_data_q, agc_data_d;
    logic [NCH-1:0]          ldctrl_q, ldctrl_d;
    logic [NCH*CTRL_W-1:0]   ctrlword_q, ctrlword_d;
    logic [NCH-1:0]          enable_q, enable_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [15:0]             frame_q, frame_d;
    logic [CNT_W-1:0]        cur_t_s;
    logic [CNT_W-1:0]        lim_s;
    logic                    expire_s;

    // Select the duration of the current timed state; a zero duration behaves as one cycle.
    always_comb begin
        case (state_q)
            S_AGC:    cur_t_s = t_agc_q;
            S_SETTLE: cur_t_s = t_ctrl_q;
            S_ACQ:    cur_t_s = t_acq_q;
            S_GAP:    cur_t_s = t_gap_q;
            default:  cur_t_s = CNT_ZERO;
        endcase
        if (cur_t_s == CNT_ZERO) begin
            lim_s = CNT_ZERO;
        end else begin
            lim_s = cur_t_s - CNT_ONE;
        end
        expire_s = (cnt_q >= lim_s);
    end

    // Next-state, shadow capture, frame counting and registered output values.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        t_agc_d  = t_agc_q;
        t_ctrl_d = t_ctrl_q;
        t_acq_d  = t_acq_q;
        t_gap_d  = t_gap_q;
        words_d  = words_q;
        mask_d   = mask_q;
        frame_d  = frame_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    mode_d   = mode;
                    t_agc_d  = t_agc;
                    t_ctrl_d = t_ctrl;
                    t_acq_d  = t_acq;
                    t_gap_d  = t_gap;
                    words_d  = ctrlword_in;
                    mask_d   = ch_mask;
                    frame_d  = 16'd0;
                    state_d  = S_AGC;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_AGC: begin
                if (expire_s) state_d = S_CTRL;
                else          state_d = S_AGC;
            end
            S_CTRL: state_d = S_SETTLE;
            S_SETTLE: begin
                if (expire_s) state_d = S_ACQ;
                else          state_d = S_SETTLE;
            end
            S_ACQ: begin
                // Continuous mode never lets the window timer end the frame.
                if (expire_s && (mode_q != 2'd2)) begin
                    frame_d = frame_q + 16'd1;
                    if (mode_q == 2'd1) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = S_ACQ;
                end
            end
            S_GAP: begin
                if (expire_s) state_d = S_ACQ;
                else          state_d = S_GAP;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything; a cut-short window still counts as a frame.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            if (state_q == S_ACQ) frame_d = frame_q + 16'd1;
            else                  frame_d = frame_q;
        end else begin
            done_d  = done_d;
        end

        if (state_d != state_q) begin
            cnt_d = CNT_ZERO;
        end else if ((state_q == S_ACQ) && (mode_q == 2'd2)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        agc_load_d = (state_d == S_AGC) && (state_q != S_AGC);
        if ((state_q == S_IDLE) && (state_d == S_AGC)) agc_data_d = agc_code;
        else                                           agc_data_d = agc_data_q;
        if (state_d == S_CTRL) begin
            ldctrl_d   = mask_q;
            ctrlword_d = words_q;
        end else begin
            ldctrl_d   = {NCH{1'b0}};
            ctrlword_d = ctrlword_q;
        end
        if (state_d == S_ACQ) enable_d = mask_q;
        else                  enable_d = {NCH{1'b0}};
        busy_d = (state_d != S_IDLE);
    end

    // State, shadow and output registers; reset drops enables without waiting for a clock.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= CNT_ZERO;
            mode_q     <= 2'd0;
            t_agc_q    <= CNT_ZERO;
            t_ctrl_q   <= CNT_ZERO;
            t_acq_q    <= CNT_ZERO;
            t_gap_q    <= CNT_ZERO;
            words_q    <= {(NCH*CTRL_W){1'b0}};
            mask_q     <= {NCH{1'b0}};
            agc_load_q <= 1'b0;
            agc_data_q <= AGC_RST;
            ldctrl_q   <= {NCH{1'b0}};
            ctrlword_q <= {(NCH*CTRL_W){1'b0}};
            enable_q   <= {NCH{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            frame_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            t_agc_q    <= t_agc_d;
            t_ctrl_q   <= t_ctrl_d;
            t_acq_q    <= t_acq_d;
            t_gap_q    <= t_gap_d;
            words_q    <= words_d;
            mask_q     <= mask_d;
            agc_load_q <= agc_load_d;
            agc_data_q <= agc_data_d;
            ldctrl_q   <= ldctrl_d;
            ctrlword_q <= ctrlword_d;
            enable_q   <= enable_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            frame_q    <= frame_d;
        end
    end

    assign agc_load     = agc_load_q;
    assign agc_data     = agc_data_q;
    assign adc_ldctrl   = ldctrl_q;
    assign adc_ctrlword = ctrlword_q;
    assign adc_enable   = enable_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign frame_cnt    = frame_q;

endmodule
